// File: rtl/seg_pkg.sv
// Shared types, constants and digit helpers for the seven-segment display scheduler.
package seg_pkg;

    typedef enum logic [2:0] {IDLE, SELECT, CONVERT, LATCH, DWELL} sched_state_t;

    localparam logic [3:0]  BLANK_DIGIT = 4'hF;
    localparam logic [13:0] MAX_DISPLAY = 14'd9999;
    localparam int unsigned BCD_ITER    = 14;

    // Leading zeros become blank digits; the units digit always shows.
    function automatic logic [15:0] blank_leading_zeros(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        if (bcd[15:12] == 4'd0) begin
            res[15:12] = BLANK_DIGIT;
            if (bcd[11:8] == 4'd0) begin
                res[11:8] = BLANK_DIGIT;
                if (bcd[7:4] == 4'd0) begin
                    res[7:4] = BLANK_DIGIT;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits, one shift per clock.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clock_100Mhz,
    input  logic        reset_n,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [29:0] sr_q, sr_d;
    logic [3:0]  iter_q, iter_d;
    logic        run_q, run_d;
    logic [15:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (sr_q[14 + i*4 +: 4] >= 4'd5) ? sr_q[14 + i*4 +: 4] + 4'd3
                                                          : sr_q[14 + i*4 +: 4];
        end
    end

    always_comb begin
        sr_d   = sr_q;
        iter_d = iter_q;
        run_d  = run_q;
        done   = run_q && (iter_q == 4'(BCD_ITER - 1));
        if (start) begin
            sr_d   = {16'd0, bin};
            iter_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            sr_d   = {adj[14:0], sr_q[13:0], 1'b0};
            iter_d = iter_q + 4'd1;
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            iter_q <= iter_d;
            run_q  <= run_d;
        end
    end

    assign bcd = sr_q[29:14];

endmodule

// File: rtl/seg_display_scheduler.sv
// Round-robin / urgent-preemptive scheduler sharing a 4-digit BCD display between sources.
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DATA_W       = 14,
    parameter int unsigned DWELL_CYCLES = 200_000_000
) (
    input  logic                      clock_100Mhz,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_urgent,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    output logic [15:0]               disp_bcd,
    output logic [2:0]                disp_src,
    output logic                      disp_valid,
    output logic                      disp_ovf,
    output logic                      busy
);

    sched_state_t      state_q, state_d;
    logic [2:0]        sel_q, sel_d, last_q, last_d;
    logic [DATA_W-1:0] raw_q, raw_d;
    logic              ovf_q, ovf_d, live_q, live_d;
    logic [31:0]       dwell_q, dwell_d, dwell_dec;
    logic [15:0]       bcd_q, bcd_d;
    logic [2:0]        src_q, src_d;
    logic              vld_q, vld_d, dovf_q, dovf_d;

    logic              conv_start, conv_done;
    logic [13:0]       conv_bin;
    logic [15:0]       conv_bcd;

    logic [7:0]        valid_ext, urgent_ext;
    logic [DATA_W-1:0] value_arr [8];
    logic [3:0]        pick;
    logic [DATA_W-1:0] pick_value, cur_value;
    logic              cur_valid, cur_urgent, other_urgent;

    function automatic logic over_max(input logic [DATA_W-1:0] v);
        return 32'(v) > 32'(MAX_DISPLAY);
    endfunction

    function automatic logic [13:0] clamp(input logic [DATA_W-1:0] v);
        return over_max(v) ? MAX_DISPLAY : 14'(v);
    endfunction

    // {found, index}: lowest valid urgent source, else next valid after last, last itself last.
    function automatic logic [3:0] pick_source(input logic [7:0] valid, input logic [7:0] urgent,
                                               input logic [2:0] last);
        logic       found;
        logic [2:0] idx;
        int         j;
        found = 1'b0;
        idx   = last;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (valid[3'(i)] && urgent[3'(i)]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
        if (!found) begin
            for (int k = 1; k <= int'(NUM_SRC); k++) begin
                j = (int'(last) + k) % int'(NUM_SRC);
                if (!found && valid[3'(j)]) begin
                    found = 1'b1;
                    idx   = 3'(j);
                end
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        valid_ext  = 8'(src_valid);
        urgent_ext = 8'(src_urgent);
        for (int i = 0; i < 8; i++) begin
            value_arr[i] = '0;
        end
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            value_arr[i] = src_value[i*DATA_W +: DATA_W];
        end
    end

    assign pick         = pick_source(valid_ext, urgent_ext, last_q);
    assign pick_value   = value_arr[pick[2:0]];
    assign cur_value    = value_arr[sel_q];
    assign cur_valid    = valid_ext[sel_q];
    assign cur_urgent   = cur_valid && urgent_ext[sel_q];
    assign other_urgent = |(valid_ext & urgent_ext & ~(8'd1 << sel_q));
    assign dwell_dec    = (dwell_q != 32'd0) ? dwell_q - 32'd1 : 32'd0;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        raw_d      = raw_q;
        ovf_d      = ovf_q;
        live_d     = live_q;
        dwell_d    = dwell_q;
        bcd_d      = bcd_q;
        src_d      = src_q;
        vld_d      = vld_q;
        dovf_d     = dovf_q;
        conv_start = 1'b0;
        conv_bin   = clamp(cur_value);
        unique case (state_q)
            IDLE: begin
                if (|src_valid) state_d = SELECT;
            end
            SELECT: begin
                if (pick[3]) begin
                    sel_d      = pick[2:0];
                    last_d     = pick[2:0];
                    raw_d      = pick_value;
                    ovf_d      = over_max(pick_value);
                    live_d     = 1'b0;
                    conv_start = 1'b1;
                    conv_bin   = clamp(pick_value);
                    state_d    = CONVERT;
                end else begin
                    bcd_d   = {4{BLANK_DIGIT}};
                    vld_d   = 1'b0;
                    dovf_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                if (live_q) dwell_d = dwell_dec;
                if (conv_done) state_d = LATCH;
            end
            LATCH: begin
                bcd_d   = blank_leading_zeros(conv_bcd);
                src_d   = sel_q;
                vld_d   = 1'b1;
                dovf_d  = ovf_q;
                // A live update keeps counting down the dwell already in progress.
                dwell_d = live_q ? dwell_dec : 32'(DWELL_CYCLES - 1);
                state_d = DWELL;
            end
            DWELL: begin
                if (!cur_valid || (other_urgent && !cur_urgent) || dwell_q == 32'd0) begin
                    state_d = SELECT;
                end else if (cur_value != raw_q) begin
                    raw_d      = cur_value;
                    ovf_d      = over_max(cur_value);
                    live_d     = 1'b1;
                    conv_start = 1'b1;
                    dwell_d    = dwell_dec;
                    state_d    = CONVERT;
                end else begin
                    dwell_d = dwell_dec;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= 3'(NUM_SRC - 1);
            raw_q   <= '0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
            dwell_q <= '0;
            bcd_q   <= {4{BLANK_DIGIT}};
            src_q   <= '0;
            vld_q   <= 1'b0;
            dovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            raw_q   <= raw_d;
            ovf_q   <= ovf_d;
            live_q  <= live_d;
            dwell_q <= dwell_d;
            bcd_q   <= bcd_d;
            src_q   <= src_d;
            vld_q   <= vld_d;
            dovf_q  <= dovf_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .start        (conv_start),
        .bin          (conv_bin),
        .done         (conv_done),
        .bcd          (conv_bcd)
    );

    assign disp_bcd   = bcd_q;
    assign disp_src   = src_q;
    assign disp_valid = vld_q;
    assign disp_ovf   = dovf_q;
    assign busy       = (state_q == CONVERT);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler against an arithmetic reference model.
module tb_seg_display_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 14;
    localparam int DWELL   = 8;

    logic                      clock_100Mhz;
    logic                      reset_n;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_urgent;
    logic [NUM_SRC*DATA_W-1:0] src_value;
    logic [15:0]               disp_bcd;
    logic [2:0]                disp_src;
    logic                      disp_valid;
    logic                      disp_ovf;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    seg_display_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DATA_W       (DATA_W),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .src_valid    (src_valid),
        .src_urgent   (src_urgent),
        .src_value    (src_value),
        .disp_bcd     (disp_bcd),
        .disp_src     (disp_src),
        .disp_valid   (disp_valid),
        .disp_ovf     (disp_ovf),
        .busy         (busy)
    );

    initial clock_100Mhz = 1'b0;
    always #5 clock_100Mhz = ~clock_100Mhz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_bcd(input int v);
        int c;
        logic [3:0] d3, d2, d1, d0;
        c  = (v > 9999) ? 9999 : v;
        d3 = 4'(c / 1000);
        d2 = 4'((c / 100) % 10);
        d1 = 4'((c / 10) % 10);
        d0 = 4'(c % 10);
        if (c < 1000) d3 = 4'hF;
        if (c < 100)  d2 = 4'hF;
        if (c < 10)   d1 = 4'hF;
        return {d3, d2, d1, d0};
    endfunction

    function automatic int model_next(input logic [3:0] valid, input logic [3:0] urgent,
                                      input int last);
        for (int i = 0; i < NUM_SRC; i++) if (valid[i] && urgent[i]) return i;
        for (int k = 1; k <= NUM_SRC; k++) if (valid[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
        return -1;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic set_value(input int idx, input int v);
        src_value[idx*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; src_valid = '0; src_urgent = '0; src_value = '0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    // Runs until busy falls and the following LATCH edge has written the display.
    task automatic wait_latch(input int limit, output int n, output int nbusy);
        bit seen = 0;
        bit done = 0;
        n = 0; nbusy = 0;
        while (!done && n < limit) begin
            tick(); n++;
            if (busy) begin seen = 1; nbusy++; end
            else if (seen) begin tick(); n++; done = 1; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_latch: no display update within %0d clocks", limit);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b1; src_valid = '0; src_urgent = '0; src_value = '0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (disp_bcd !== 16'hFFFF) begin errors++; $display("FAIL reset_bcd: got %h want ffff", disp_bcd); end
        checks++; if (disp_src !== 3'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", disp_src); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", disp_valid); end
        checks++; if (disp_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", disp_ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick(); tick();
        reset_n = 1'b1;
        repeat (4) tick();
        checks++; if (disp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: valid %b busy %b want 0 0", disp_valid, busy); end
    endtask

    task automatic test_single_source();
        int n, nb;
        do_reset();
        set_value(0, 1234); src_valid = 4'b0001;
        wait_latch(40, n, nb);
        checks++; if (n !== 17) begin errors++; $display("FAIL single_latency: got %0d want 17", n); end
        checks++; if (nb !== 14) begin errors++; $display("FAIL single_busy_len: got %0d want 14", nb); end
        checks++; if (disp_bcd !== 16'h1234) begin errors++; $display("FAIL single_bcd: got %h want 1234", disp_bcd); end
        checks++; if (disp_src !== 3'd0 || disp_valid !== 1'b1) begin errors++; $display("FAIL single_src_valid: got %0d/%b want 0/1", disp_src, disp_valid); end
        wait_latch(60, n, nb);
        checks++; if (n !== DWELL + 16) begin errors++; $display("FAIL single_reselect_time: got %0d want %0d", n, DWELL + 16); end
        checks++; if (disp_bcd !== 16'h1234 || disp_src !== 3'd0) begin errors++; $display("FAIL single_reselect: got %h/%0d want 1234/0", disp_bcd, disp_src); end
    endtask

    task automatic run_rr(input logic [3:0] mask, input int v0, input int v1, input int v2,
                          input int v3, input int nlatch, input string tag);
        int vals[4];
        int last, exp_src, n, nb;
        vals = '{v0, v1, v2, v3};
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_value(i, vals[i]);
        src_valid = mask;
        last = NUM_SRC - 1;
        for (int k = 0; k < nlatch; k++) begin
            exp_src = model_next(mask, 4'b0000, last);
            last = exp_src;
            wait_latch(60, n, nb);
            checks++; if (n !== ((k == 0) ? 17 : DWELL + 16)) begin errors++; $display("FAIL %s_time[%0d]: got %0d want %0d", tag, k, n, (k == 0) ? 17 : DWELL + 16); end
            checks++; if (disp_src !== 3'(exp_src)) begin errors++; $display("FAIL %s_src[%0d]: got %0d want %0d", tag, k, disp_src, exp_src); end
            checks++; if (disp_bcd !== model_bcd(vals[exp_src])) begin errors++; $display("FAIL %s_bcd[%0d]: got %h want %h", tag, k, disp_bcd, model_bcd(vals[exp_src])); end
            checks++; if (disp_ovf !== (vals[exp_src] > 9999)) begin errors++; $display("FAIL %s_ovf[%0d]: got %b want %b", tag, k, disp_ovf, vals[exp_src] > 9999); end
        end
    endtask

    task automatic test_round_robin();
        run_rr(4'b0111, 7, 45, 9999, 0, 4, "rr_fixed");
        for (int r = 0; r < 3; r++) begin
            run_rr(4'($urandom_range(1, 15)), int'($urandom_range(0, 16383)),
                   int'($urandom_range(0, 16383)), int'($urandom_range(0, 999)),
                   int'($urandom_range(0, 99)), 5, "rr_rand");
        end
    endtask

    task automatic test_overflow();
        int n, nb, v, prev;
        do_reset();
        set_value(1, 12000); src_valid = 4'b0010;
        wait_latch(40, n, nb);
        checks++; if (disp_bcd !== 16'h9999 || disp_ovf !== 1'b1 || disp_src !== 3'd1) begin errors++; $display("FAIL ovf_clamp: got %h/%b/%0d want 9999/1/1", disp_bcd, disp_ovf, disp_src); end
        set_value(1, 0);
        wait_latch(40, n, nb);
        checks++; if (disp_bcd !== 16'hFFF0 || disp_ovf !== 1'b0) begin errors++; $display("FAIL ovf_zero: got %h/%b want fff0/0", disp_bcd, disp_ovf); end
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            do v = (k % 2 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            while (v == prev);
            prev = v;
            set_value(1, v);
            wait_latch(60, n, nb);
            checks++; if (disp_bcd !== model_bcd(v) || disp_ovf !== (v > 9999)) begin errors++; $display("FAIL ovf_rand[%0d]: value %0d got %h/%b want %h/%b", k, v, disp_bcd, disp_ovf, model_bcd(v), v > 9999); end
        end
    endtask

    task automatic test_preempt_dwell();
        int n, nb, v0;
        do_reset();
        v0 = int'($urandom_range(0, 9999));
        set_value(0, v0); set_value(3, 42); src_valid = 4'b1001;
        wait_latch(40, n, nb);
        checks++; if (disp_src !== 3'd0 || disp_bcd !== model_bcd(v0)) begin errors++; $display("FAIL pre_first: got %0d/%h want 0/%h", disp_src, disp_bcd, model_bcd(v0)); end
        tick(); tick();
        src_urgent = 4'b1000;
        tick(); tick();
        // SELECT on the next edge, so CONVERT (busy) is reached on the edge after.
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_select_next: busy got %b want 1", busy); end
        wait_latch(40, n, nb);
        checks++; if (n + 2 !== 17) begin errors++; $display("FAIL pre_latency: got %0d want 17", n + 2); end
        checks++; if (disp_src !== 3'(model_next(src_valid, src_urgent, 0)) || disp_bcd !== 16'hFF42) begin errors++; $display("FAIL pre_show: got %0d/%h want 3/ff42", disp_src, disp_bcd); end
        wait_latch(60, n, nb);
        checks++; if (n !== DWELL + 16 || disp_src !== 3'd3) begin errors++; $display("FAIL pre_hold: got %0d/%0d want %0d/3", n, disp_src, DWELL + 16); end
    endtask

    task automatic test_urgent_mid_convert();
        int n, nb, v0;
        do_reset();
        v0 = int'($urandom_range(0, 9999));
        set_value(0, v0); set_value(3, 42); src_valid = 4'b1001;
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        src_urgent = 4'b1000;
        wait_latch(40, n, nb);
        checks++; if (n !== 12 || disp_src !== 3'd0 || disp_bcd !== model_bcd(v0)) begin errors++; $display("FAIL mid_no_abort: got %0d/%0d/%h want 12/0/%h", n, disp_src, disp_bcd, model_bcd(v0)); end
        wait_latch(40, n, nb);
        checks++; if (n !== 17 || disp_src !== 3'd3 || disp_bcd !== 16'hFF42) begin errors++; $display("FAIL mid_then_preempt: got %0d/%0d/%h want 17/3/ff42", n, disp_src, disp_bcd); end
    endtask

    task automatic test_live_update();
        int n, nb;
        do_reset();
        set_value(0, 100); set_value(1, 500); src_valid = 4'b0011;
        wait_latch(40, n, nb);
        checks++; if (disp_bcd !== 16'hF100 || disp_src !== 3'd0) begin errors++; $display("FAIL live_first: got %h/%0d want f100/0", disp_bcd, disp_src); end
        tick(); tick();
        set_value(0, 101);
        n = 0;
        while (disp_bcd === 16'hF100 && n < 40) begin tick(); n++; end
        // First edge samples the change in DWELL, then CONVERT 14 + LATCH 1.
        checks++; if (n !== 1 + 15) begin errors++; $display("FAIL live_latency: got %0d want 16", n); end
        checks++; if (disp_bcd !== 16'hF101 || disp_src !== 3'd0) begin errors++; $display("FAIL live_value: got %h/%0d want f101/0", disp_bcd, disp_src); end
        // The dwell already expired while converting, so rotation resumes at once.
        wait_latch(60, n, nb);
        checks++; if (n !== 1 + 16 || disp_src !== 3'd1 || disp_bcd !== 16'hF500) begin errors++; $display("FAIL live_no_extend: got %0d/%0d/%h want 17/1/f500", n, disp_src, disp_bcd); end
    endtask

    task automatic test_async_reset();
        int n, nb, v0;
        do_reset();
        set_value(1, 12000); src_valid = 4'b0010;
        wait_latch(40, n, nb);
        repeat (10) tick();
        checks++; if (busy !== 1'b1 || disp_ovf !== 1'b1 || disp_src !== 3'd1) begin errors++; $display("FAIL ar_pre: busy %b ovf %b src %0d want 1 1 1", busy, disp_ovf, disp_src); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (disp_bcd !== 16'hFFFF || disp_src !== 3'd0 || disp_valid !== 1'b0 || disp_ovf !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_immediate: got %h/%0d/%b/%b/%b want ffff/0/0/0/0", disp_bcd, disp_src, disp_valid, disp_ovf, busy); end
        tick();
        reset_n = 1'b1;
        v0 = int'($urandom_range(0, 16383));
        set_value(0, v0); set_value(2, 77); set_value(3, 5); src_valid = 4'b1111;
        wait_latch(40, n, nb);
        checks++; if (n !== 17 || disp_src !== 3'd0 || disp_bcd !== model_bcd(v0)) begin errors++; $display("FAIL ar_restart: got %0d/%0d/%h want 17/0/%h", n, disp_src, disp_bcd, model_bcd(v0)); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_overflow();
        test_preempt_dwell();
        test_urgent_mid_convert();
        test_live_update();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
